// File: rtl/tb_clk_ctrl_mc.sv
// Multi-channel bench clock controller: per-channel divided clocks with free-run (auto) or counted-burst (manual) modes.
// Define TB_CLK_CTRL_CYCLE_CNT_EN to add a 32-bit rising-edge counter per channel on cyc_count.
module tb_clk_ctrl_mc #(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned DIV_W  = 8,
  parameter  int unsigned STEP_W = 8,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    nRst,
  input  logic [NUM_CH-1:0]       nEnable,
  input  logic [NUM_CH-1:0]       manual,
  input  logic [NUM_CH*DIV_W-1:0] half_period,
  input  logic                    step_valid,
  input  logic [CH_W-1:0]         step_ch,
  input  logic [STEP_W-1:0]       step_count,
  output logic                    step_ready,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       rise_strobe,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       steps_done,
  output logic [NUM_CH*32-1:0]    cyc_count
);

  typedef enum logic [1:0] {S_IDLE, S_AUTO, S_STEP, S_DRAIN} state_e;

  // Per-channel "this channel could take the current request" terms.
  logic [NUM_CH-1:0] req_ok;

  // An out-of-range step_ch matches no channel, so it is never ready.
  assign step_ready = nRst & (|req_ok);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic              clk_q, clk_d;
    logic              rise_q, rise_d;
    logic              done_q, done_d;
    logic              busy_q;
    logic              hit;
    logic              stop;
    logic              accept;

    assign req_ok[i] = (step_ch == CH_W'(i)) && (state_q == S_IDLE) && manual[i] && !nEnable[i];
    assign accept    = step_valid && step_ready && req_ok[i];
    assign hit       = (cnt_q == half_period[i*DIV_W +: DIV_W]);
    // Manual changes are ignored during a burst; DRAIN always runs to the falling toggle.
    assign stop      = (state_q == S_DRAIN) || nEnable[i] || ((state_q == S_AUTO) && manual[i]);

    always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        rem_q   <= '0;
        clk_q   <= 1'b0;
        rise_q  <= 1'b0;
        done_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rem_q   <= rem_d;
        clk_q   <= clk_d;
        rise_q  <= rise_d;
        done_q  <= done_d;
        busy_q  <= (state_d != S_IDLE);
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      clk_d   = clk_q;
      rise_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          clk_d = 1'b0;
          if (accept) begin
            if (step_count == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = S_STEP;
              rem_d   = step_count;
            end
          end else if (!nEnable[i] && !manual[i]) begin
            state_d = S_AUTO;
          end
        end
        default: begin
          // Stopping while low is immediate; while high we wait for the falling toggle.
          if (stop && !clk_q) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (hit) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            rise_d = ~clk_q;
            if (clk_q) begin
              if (stop) begin
                state_d = S_IDLE;
              end else if (state_q == S_STEP) begin
                rem_d = rem_q - STEP_W'(1);
                if (rem_q == STEP_W'(1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end
              end
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
            if (stop) state_d = S_DRAIN;
          end
        end
      endcase
    end

    assign clk_out[i]     = clk_q;
    assign rise_strobe[i] = rise_q;
    assign busy[i]        = busy_q;
    assign steps_done[i]  = done_q;

`ifdef TB_CLK_CTRL_CYCLE_CNT_EN
    logic [31:0] cyc_q;

    // Counts every rising edge; wraps naturally, cleared only by reset.
    always_ff @(posedge clk or negedge nRst) begin
      if (!nRst)       cyc_q <= '0;
      else if (rise_d) cyc_q <= cyc_q + 32'd1;
    end

    assign cyc_count[i*32 +: 32] = cyc_q;
`else
    assign cyc_count[i*32 +: 32] = 32'd0;
`endif
  end

endmodule

// File: tb/tb_tb_clk_ctrl_mc.sv
// Bench for tb_clk_ctrl_mc: directed scenarios with hand-computed expectations plus randomized traffic,
// all cycles checked against an elapsed-time behavioural model of each channel.
module tb_tb_clk_ctrl_mc;
  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int SW  = 8;
  localparam int CW  = 2;

  logic              clk = 1'b0;
  logic              nRst;
  logic [NCH-1:0]    nEnable;
  logic [NCH-1:0]    manual;
  logic [NCH*DW-1:0] half_period;
  logic              step_valid;
  logic [CW-1:0]     step_ch;
  logic [SW-1:0]     step_count;
  logic              step_ready;
  logic [NCH-1:0]    clk_out;
  logic [NCH-1:0]    rise_strobe;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    steps_done;
  logic [NCH*32-1:0] cyc_count;

  tb_clk_ctrl_mc #(.NUM_CH(NCH), .DIV_W(DW), .STEP_W(SW)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .nEnable    (nEnable),
    .manual     (manual),
    .half_period(half_period),
    .step_valid (step_valid),
    .step_ch    (step_ch),
    .step_count (step_count),
    .step_ready (step_ready),
    .clk_out    (clk_out),
    .rise_strobe(rise_strobe),
    .busy       (busy),
    .steps_done (steps_done),
    .cyc_count  (cyc_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: activity kind (0 none, 1 free run, 2 burst), edges elapsed since start, pulses seen/wanted.
  int          m_act[NCH];
  bit          m_drain[NCH];
  int          m_k[NCH];
  int          m_want[NCH];
  int          m_rises[NCH];
  bit          m_lvl[NCH];
  bit          m_rise[NCH];
  bit          m_done[NCH];
  int unsigned m_cyc[NCH];
  int          hp_v[NCH];
  bit          m_acc;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_act[i] = 0; m_drain[i] = 0; m_k[i] = 0; m_want[i] = 0; m_rises[i] = 0;
      m_lvl[i] = 0; m_rise[i] = 0; m_done[i] = 0; m_cyc[i] = 0;
    end
    m_acc = 0;
  endfunction

  function automatic bit m_ready();
    int c;
    c = int'(step_ch);
    if (nRst !== 1'b1 || c >= NCH) return 1'b0;
    return (m_act[c] == 0) && manual[c] && !nEnable[c];
  endfunction

  function automatic void m_step();
    bit acc;
    if (nRst !== 1'b1) begin
      m_reset();
      return;
    end
    acc   = step_valid && m_ready();
    m_acc = acc;
    for (int i = 0; i < NCH; i++) begin
      m_rise[i] = 0;
      m_done[i] = 0;
      if (m_act[i] == 0) begin
        if (acc && int'(step_ch) == i) begin
          if (step_count == 0) m_done[i] = 1;
          else begin
            m_act[i] = 2; m_k[i] = 0; m_want[i] = int'(step_count); m_rises[i] = 0; m_drain[i] = 0;
          end
        end else if (!nEnable[i] && !manual[i]) begin
          m_act[i] = 1; m_k[i] = 0; m_rises[i] = 0; m_drain[i] = 0;
        end
      end else begin
        bit stop;
        int per;
        stop = m_drain[i] || nEnable[i] || (m_act[i] == 1 && manual[i]);
        per  = hp_v[i] + 1;
        if (stop && !m_lvl[i]) begin
          m_act[i] = 0;
        end else begin
          m_k[i]++;
          if (m_k[i] % per == 0) begin
            m_lvl[i] = ((m_k[i] / per) % 2) == 1;
            if (m_lvl[i]) begin
              m_rise[i] = 1;
              m_rises[i]++;
              m_cyc[i]++;
            end else if (stop) begin
              m_act[i] = 0;
            end else if (m_act[i] == 2 && m_rises[i] == m_want[i]) begin
              m_act[i]  = 0;
              m_done[i] = 1;
            end
          end else if (stop) begin
            m_drain[i] = 1;
          end
        end
      end
    end
  endfunction

  task automatic check_outs();
    logic [NCH-1:0] ec, er, eb, ed;
    for (int i = 0; i < NCH; i++) begin
      ec[i] = m_lvl[i];
      er[i] = m_rise[i];
      eb[i] = (m_act[i] != 0);
      ed[i] = m_done[i];
    end
    chk("clk_out", 64'(clk_out), 64'(ec));
    chk("rise_strobe", 64'(rise_strobe), 64'(er));
    chk("busy", 64'(busy), 64'(eb));
    chk("steps_done", 64'(steps_done), 64'(ed));
    for (int i = 0; i < NCH; i++) begin
`ifdef TB_CLK_CTRL_CYCLE_CNT_EN
      chk("cyc_count", 64'(cyc_count[i*32 +: 32]), 64'(m_cyc[i]));
`else
      chk("cyc_count", 64'(cyc_count[i*32 +: 32]), 64'd0);
`endif
    end
  endtask

  // Called at a negedge with inputs already driven.
  task automatic tick();
    #1 chk("step_ready", 64'(step_ready), 64'(m_ready()));
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_outs();
  endtask

  task automatic set_hp(input int i, input int v);
    hp_v[i] = v;
    half_period[i*DW +: DW] = DW'(v);
  endtask

  task automatic do_reset();
    nEnable    = '1;
    manual     = '0;
    step_valid = 1'b0;
    step_ch    = '0;
    step_count = '0;
    nRst       = 1'b0;
    m_reset();
    #1;
    check_outs();
    chk("reset_ready", 64'(step_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    nRst = 1'b1;
  endtask

  int  rt[3];
  int  r, highs, dones, rises, cnt, found, done_at;
  bit  pend;
  int  age, k;

  initial begin
    half_period = '0;
    for (int i = 0; i < NCH; i++) hp_v[i] = 0;

    // Auto run, half_period 2: period 6, first rise 3 edges after entering run.
    do_reset();
    set_hp(0, 2);
    nEnable[0] = 1'b0;
    r = 0; highs = 0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (rise_strobe[0] && r < 3) begin rt[r] = c; r++; end
      if (c >= 4 && c <= 15 && clk_out[0]) highs++;
    end
    chk("auto_first_rise", 64'(rt[0]), 64'd4);
    chk("auto_second_rise", 64'(rt[1]), 64'd10);
    chk("auto_third_rise", 64'(rt[2]), 64'd16);
    chk("auto_duty", 64'(highs), 64'd6);
    nEnable[0] = 1'b1;
    for (int c = 0; c < 10; c++) tick();

    // Glitch-free stop: high phase of 5 cycles survives enable removal.
    do_reset();
    set_hp(0, 4);
    nEnable[0] = 1'b0;
    found = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (rise_strobe[0]) begin found = c; break; end
    end
    chk("stop_first_rise", 64'(found), 64'd6);
    highs = 1;
    tick();
    if (clk_out[0]) highs++;
    nEnable[0] = 1'b1;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!clk_out[0]) begin found = 1; break; end
      highs++;
    end
    chk("stop_fell", 64'(found), 64'd1);
    chk("stop_high_len", 64'(highs), 64'd5);
    chk("stop_busy", 64'(busy[0]), 64'd0);
    tick(); tick();
    chk("stop_stays_low", 64'(clk_out[0]), 64'd0);

    // Manual burst of 3 at half_period 0.
    do_reset();
    set_hp(1, 0);
    manual[1] = 1'b1; nEnable[1] = 1'b0;
    step_ch = 2'd1; step_count = 8'd3; step_valid = 1'b1;
    #1 chk("burst_ready", 64'(step_ready), 64'd1);
    tick();
    step_valid = 1'b0;
    rises = 0; dones = 0; done_at = 0; cnt = 0;
    for (int c = 2; c <= 12; c++) begin
      tick();
      if (rise_strobe[1]) rises++;
      if (steps_done[1]) begin dones++; done_at = c; end
      if (busy[1] && step_ready) cnt++;
    end
    chk("burst_rises", 64'(rises), 64'd3);
    chk("burst_done_count", 64'(dones), 64'd1);
    chk("burst_done_cycle", 64'(done_at), 64'd7);
    chk("burst_ready_while_busy", 64'(cnt), 64'd0);

    // Zero-length step on channel 2.
    do_reset();
    manual[2] = 1'b1; nEnable[2] = 1'b0;
    step_ch = 2'd2; step_count = 8'd0; step_valid = 1'b1;
    tick();
    step_valid = 1'b0;
    chk("zero_done_next", 64'(steps_done[2]), 64'd1);
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      cnt += int'(clk_out[2]) + int'(steps_done[2]) + int'(busy[2]);
    end
    chk("zero_quiet", 64'(cnt), 64'd0);

    // Abort a 5-pulse burst after the second rise.
    do_reset();
    set_hp(1, 1);
    manual[1] = 1'b1; nEnable[1] = 1'b0;
    step_ch = 2'd1; step_count = 8'd5; step_valid = 1'b1;
    tick();
    step_valid = 1'b0;
    rises = 0; found = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rise_strobe[1]) rises++;
      if (rises == 2) begin found = 1; break; end
    end
    chk("abort_reach_second", 64'(found), 64'd1);
    nEnable[1] = 1'b1;
    highs = 1; dones = 0; rises = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (clk_out[1]) highs++;
      if (rise_strobe[1]) rises++;
      if (steps_done[1]) dones++;
    end
    chk("abort_high_len", 64'(highs), 64'd2);
    chk("abort_no_done", 64'(dones), 64'd0);
    chk("abort_no_more_rises", 64'(rises), 64'd0);
    chk("abort_idle", 64'(busy[1]), 64'd0);
`ifdef TB_CLK_CTRL_CYCLE_CNT_EN
    chk("abort_cyc_count", 64'(cyc_count[32 +: 32]), 64'd2);
`endif

    // Reset in the middle of a burst.
    nEnable[1] = 1'b0; step_count = 8'd5; step_valid = 1'b1;
    tick();
    step_valid = 1'b0;
    tick(); tick(); tick();
    chk("midreset_was_high", 64'(clk_out[1]), 64'd1);
    nRst = 1'b0;
    m_reset();
    #1;
    chk("midreset_clk_out", 64'(clk_out), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_strobes", 64'({rise_strobe, steps_done}), 64'd0);
    chk("midreset_ready", 64'(step_ready), 64'd0);
    chk("midreset_cyc_count", 64'(cyc_count), 64'd0);
    @(negedge clk);
    @(negedge clk);
    nRst = 1'b1;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (steps_done[1]) dones++;
    end
    chk("midreset_no_done", 64'(dones), 64'd0);

    // Illegal channel and request blocked by a free-running target.
    do_reset();
    manual = '1; nEnable = '0;
    step_ch = 2'd3; step_count = 8'd1; step_valid = 1'b1;
    #1 chk("illegal_ch_ready", 64'(step_ready), 64'd0);
    tick(); tick();
    step_valid = 1'b0;
    manual[0] = 1'b0;
    set_hp(0, 1);
    tick(); tick(); tick();
    step_ch = 2'd0; step_count = 8'd2; step_valid = 1'b1;
    #1 chk("auto_target_ready", 64'(step_ready), 64'd0);
    tick();
    manual[0] = 1'b1;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m_acc) begin found = 1; break; end
    end
    chk("held_accepted", 64'(found), 64'd1);
    step_valid = 1'b0;
    rises = 0; dones = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (rise_strobe[0]) rises++;
      if (steps_done[0]) dones++;
    end
    chk("held_rises", 64'(rises), 64'd2);
    chk("held_done", 64'(dones), 64'd1);

    // Randomized traffic.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int i = 0; i < NCH; i++) set_hp(i, int'($urandom_range(0, 4)));
      nEnable = NCH'($urandom);
      manual  = NCH'($urandom);
      pend = 0; age = 0;
      for (int c = 0; c < 1500; c++) begin
        if ($urandom_range(0, 19) == 0) begin
          k = int'($urandom_range(0, NCH - 1));
          nEnable[k] = ~nEnable[k];
        end
        if ($urandom_range(0, 24) == 0) begin
          k = int'($urandom_range(0, NCH - 1));
          manual[k] = ~manual[k];
        end
        if (pend) begin
          if (m_acc || age > 30) begin
            step_valid = 1'b0;
            pend = 0;
          end else begin
            age++;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          step_ch    = CW'($urandom_range(0, 3));
          step_count = SW'($urandom_range(0, 4));
          step_valid = 1'b1;
          pend = 1;
          age  = 0;
        end
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tb_clk_ctrl_mc.md
Name: tb_clk_ctrl_mc

Overview:
- Multi-channel testbench clock controller. Derives NUM_CH divided clocks from one fast reference clock.
- Each channel runs in one of two modes:
  - automatic: free-running, gated by active-low enable;
  - manual: emits an exact requested number of pulses through a valid/ready step handshake.
- Sits between the bench top and DUT clock pins. Unit tests get glitch-free, per-channel run/stop/single-step clock control.

Parameters:
NUM_CH, 4, number of independent output clock channels (1..16)
DIV_W, 8, width of each per-channel half-period field
STEP_W, 8, width of the manual step count
CH_W, $clog2(NUM_CH) (min 1), width of channel select; derived, not overridden

Ports:
clk  in  1  reference clock; all logic on rising edge
nRst  in  1  asynchronous active-low reset
nEnable  in  NUM_CH  per-channel active-low run enable
manual  in  NUM_CH  per-channel mode: 1 = manual step, 0 = automatic
half_period  in  NUM_CH*DIV_W  per-channel half-period minus one, in clk cycles; channel i at [i*DIV_W +: DIV_W]
step_valid  in  1  step request valid
step_ch  in  CH_W  target channel of step request
step_count  in  STEP_W  number of full output pulses requested
step_ready  out  1  step request can be accepted
clk_out  out  NUM_CH  generated clocks, registered
rise_strobe  out  NUM_CH  1-cycle pulse on the cycle clk_out rises
busy  out  NUM_CH  channel not IDLE
steps_done  out  NUM_CH  1-cycle pulse when a manual burst completes
cyc_count  out  NUM_CH*32  per-channel rising-edge count (optional feature)

Behaviour:
- Reset (nRst low, async): all channels IDLE. clk_out, rise_strobe, busy, steps_done, internal counters and cyc_count are 0. step_ready is 0 while in reset.
- Divider:
  - Per-channel counter cnt.
  - When cnt == half_period[i], clk_out[i] toggles and cnt clears; otherwise cnt increments.
  - Half-period = half_period+1 clk cycles. Value 0 gives clk/2.
  - half_period is sampled at each compare, so a change takes effect from the next toggle.
- Per-channel FSM, states IDLE, AUTO, STEP, DRAIN:
  - IDLE: clk_out = 0, cnt = 0.
    - If nEnable=0 and manual=0: go to AUTO. The first rise occurs half_period+1 cycles after entry.
    - If a step is accepted for the channel: go to STEP.
  - AUTO: free-runs.
    - If nEnable=1 or manual=1 while clk_out=0: go to IDLE next cycle.
    - If clk_out=1: go to DRAIN.
  - DRAIN: completes the current high phase. At the falling toggle, clk_out=0 and the channel goes to IDLE. Truncated high pulses are never produced.
  - STEP: remaining loads step_count at accept and decrements on each falling toggle.
    - When remaining reaches 0 on a falling toggle: go to IDLE and pulse steps_done the next cycle.
    - step_count=0: no clk_out activity; steps_done pulses the cycle after accept; channel returns to IDLE.
    - nEnable rising mid-burst aborts the burst: the current high phase completes (DRAIN semantics), the channel goes to IDLE, and steps_done is not asserted.
- Handshake:
  - step_ready (combinational) = step_ch < NUM_CH AND channel step_ch is IDLE AND manual[step_ch]=1 AND nEnable[step_ch]=0.
  - Accept occurs on step_valid && step_ready.
  - step_ch, step_count and step_valid must be held until accepted.
  - Only one request per cycle.
- Mode changes:
  - A manual change during STEP is ignored until the burst ends.
  - manual 1→0 in IDLE with nEnable=0 goes to AUTO.
- rise_strobe[i] is asserted in the same cycle clk_out[i] is first seen high.
- Reset mid-burst: immediate return to reset values. No steps_done.

Optional Feature:
- Macro: TB_CLK_CTRL_CYCLE_CNT_EN.
- Defined: cyc_count[i] is a 32-bit counter, incremented on every rise_strobe[i] in both modes. It wraps from 0xFFFFFFFF to 0 and is cleared only by nRst.
- Undefined: the cyc_count port still exists, tied to 0, and no counter flops are synthesised.

Test Plan:
- Auto run: half_period[0]=2, nEnable[0]=0, manual[0]=0 → clk_out[0] period 6 cycles, 50% duty; first rise 3 cycles after IDLE exit; rise_strobe pulses every 6 cycles.
- Glitch-free stop: deassert enable (nEnable[0]=1) one cycle after a rise with half_period=4 → high phase lasts the full 5 cycles; then clk_out=0 and busy[0]=0.
- Manual burst: manual[1]=1, half_period[1]=0, step_ch=1, step_count=3 → exactly 3 rises, then steps_done[1] pulses once; step_ready low for channel 1 until IDLE.
- Zero step: step_count=0 on channel 2 → no clk_out[2] edges, steps_done[2] pulses the cycle after accept.
- Abort and reset: nEnable[1]=1 after 2 of 5 pulses → the second... current high phase completes, no steps_done. Separately, nRst low mid-burst → all outputs 0 within the same cycle. With TB_CLK_CTRL_CYCLE_CNT_EN, cyc_count[1]=2 after the abort, then 0 after reset.
- Illegal/blocked requests: step_ch=3 with NUM_CH=3, or target channel in AUTO, → step_ready=0; a held request is accepted once the channel returns to IDLE in manual mode.
